// File: rtl/vend_pkg.sv
// Shared definitions for the coin payer: coin values, coin policies, payer states.
package vend_pkg;

  localparam int unsigned COIN5         = 5;
  localparam int unsigned COIN10        = 10;
  localparam int unsigned PRICE_DEFAULT = 15;

  typedef enum logic [1:0] {
    MODE_ALL5  = 2'd0,
    MODE_EXACT = 2'd1,
    MODE_ALL10 = 2'd2
  } vend_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    COIN,
    GAP,
    WAIT,
    DONE
  } payer_state_t;

  // Coin policy: returns 1 when the next coin should be a 10, 0 for a 5.
  // Encoding 3 is not a named policy and falls through to all-5s.
  function automatic logic pick_ten(input logic [1:0] mode, input logic [5:0] remaining);
    if (mode == MODE_ALL10) return 1'b1;
    if (mode == MODE_EXACT) return (remaining >= 6'(COIN10));
    return 1'b0;
  endfunction

endpackage

// File: rtl/vend_cycle_counter.sv
// 4-bit loadable down-counter; holds at zero. Shared by the gap and timeout phases.
module vend_cycle_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] value,
  output logic       zero
);

  logic [3:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (reset)                    count <= '0;
    else if (load)                count <= value;
    else if (dec && count != '0)  count <= count - 4'd1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vend_coin_payer.sv
// Customer-side coin driver: pays PRICE as single-cycle rs5/rs10 pulses,
// then checks the machine's vend and change response.
module vend_coin_payer
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = PRICE_DEFAULT,
  parameter int unsigned COIN_GAP = 1,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       ready,
  output logic       rs5,
  output logic       rs10,
  input  logic       item1,
  input  logic       rs5out,
  output logic       done,
  output logic       error,
  output logic       change_rcvd,
  output logic [5:0] paid
);

  localparam logic [5:0] PRICE6    = 6'(PRICE);
  localparam logic [3:0] GAP_LOAD  = (COIN_GAP == 0) ? 4'd0 : 4'(COIN_GAP - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(TIMEOUT - 1);

  payer_state_t state;
  logic [1:0]   mode_q;

  logic [1:0] coin_mode;
  logic [5:0] base;
  logic [5:0] coin_add;
  logic [6:0] sum;
  logic [5:0] paid_next;
  logic [5:0] over;
  logic       next_ten;
  logic       reached;
  logic       vend_bad;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic [3:0] cnt_value;

  // Next-coin choice and running-total arithmetic. Coins are registered on
  // the edge that enters COIN, so the coin is visible for exactly the COIN cycle;
  // from IDLE the total restarts from zero with the live mode input.
  always_comb begin
    coin_mode = (state == IDLE) ? mode : mode_q;
    base      = (state == IDLE) ? '0 : paid;
    next_ten  = pick_ten(coin_mode, PRICE6 - base);
    coin_add  = next_ten ? 6'(COIN10) : 6'(COIN5);
    sum       = {1'b0, base} + {1'b0, coin_add};
    paid_next = sum[6] ? '1 : sum[5:0];
    reached   = (paid >= PRICE6);
    over      = paid - PRICE6;
    vend_bad  = (rs5out != (over == 6'd5)) || (over > 6'd5);
    // Loaded during the coin cycle: gap length if more coins follow, else timeout.
    cnt_load  = (state == COIN);
    cnt_value = reached ? WAIT_LOAD : GAP_LOAD;
    cnt_dec   = (state == GAP) || (state == WAIT);
  end

  vend_cycle_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  // Payer FSM with registered outputs; coin and done outputs default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= '0;
      ready       <= 1'b1;
      rs5         <= 1'b0;
      rs10        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      change_rcvd <= 1'b0;
      paid        <= '0;
    end else begin
      rs5  <= 1'b0;
      rs10 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q      <= mode;
            error       <= 1'b0;
            change_rcvd <= 1'b0;
            ready       <= 1'b0;
            paid        <= paid_next;
            rs10        <= next_ten;
            rs5         <= ~next_ten;
            state       <= COIN;
          end
        end
        COIN: begin
          if (item1) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (reached) begin
            state <= WAIT;
          end else if (COIN_GAP == 0) begin
            paid  <= paid_next;
            rs10  <= next_ten;
            rs5   <= ~next_ten;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          if (item1) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt_zero) begin
            paid  <= paid_next;
            rs10  <= next_ten;
            rs5   <= ~next_ten;
            state <= COIN;
          end
        end
        WAIT: begin
          if (item1) begin
            change_rcvd <= rs5out;
            error       <= vend_bad;
            done        <= 1'b1;
            state       <= DONE;
          end else if (cnt_zero) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_coin_payer.sv
// Bench for vend_coin_payer: timeline-based reference model plus directed cases.
module tb_vend_coin_payer;

  localparam int PRICE = 15;
  localparam int GAP   = 1;
  localparam int TOUT  = 8;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       start  = 1'b0;
  logic [1:0] mode   = 2'd0;
  logic       item1  = 1'b0;
  logic       rs5out = 1'b0;
  logic       ready, rs5, rs10, done, error, change_rcvd;
  logic [5:0] paid;

  int tests = 0;
  int fails = 0;

  vend_coin_payer #(.PRICE(PRICE), .COIN_GAP(GAP), .TIMEOUT(TOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .ready       (ready),
    .rs5         (rs5),
    .rs10        (rs10),
    .item1       (item1),
    .rs5out      (rs5out),
    .done        (done),
    .error       (error),
    .change_rcvd (change_rcvd),
    .paid        (paid)
  );

  always #5 clk = ~clk;

  // Reference model: a transaction is a list of (cycle, coin value) pairs plus
  // the cycle its done pulse lands on; outputs are read off that timeline.
  int k = 0;
  bit m_active = 0, m_ended = 0, m_err = 0, m_chg = 0;
  int m_last = 0, m_done_cyc = 0;
  int ct[$];
  int cv[$];
  bit chk_en = 0;
  logic       exp_ready = 1, exp_rs5 = 0, exp_rs10 = 0, exp_done = 0, exp_err = 0, exp_chg = 0;
  logic [5:0] exp_paid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, k);
    end
  endtask

  function automatic int coin_for(input int md, input int rem);
    if (md == 2) return 10;
    if (md == 1 && rem >= 10) return 10;
    return 5;
  endfunction

  function automatic int total();
    int s = 0;
    foreach (cv[i]) s += cv[i];
    return s;
  endfunction

  // Called just after each rising edge; inputs still hold the values sampled there.
  task automatic model_edge();
    k++;
    if (reset) begin
      m_active = 0; m_ended = 0; m_err = 0; m_chg = 0;
      ct.delete(); cv.delete();
    end else begin
      if (m_active && !m_ended) begin
        if (item1 && (k - 1) <= m_last) begin
          m_ended = 1; m_done_cyc = k; m_err = 1;
          while (ct.size() > 0 && ct[ct.size()-1] >= k) begin
            void'(ct.pop_back());
            void'(cv.pop_back());
          end
        end else if (item1) begin
          int over;
          over = total() - PRICE;
          m_ended = 1; m_done_cyc = k; m_chg = rs5out;
          m_err = (rs5out != (over == 5)) || (over > 5);
        end else if (k == m_last + TOUT + 1) begin
          m_ended = 1; m_done_cyc = k; m_err = 1;
        end
      end else if (!m_active && start) begin
        int p = 0;
        int i = 0;
        ct.delete(); cv.delete();
        while (p < PRICE) begin
          int v;
          v = coin_for(int'(mode), PRICE - p);
          ct.push_back(k + i * (GAP + 1));
          cv.push_back(v);
          p += v;
          i++;
        end
        m_last = ct[ct.size()-1];
        m_active = 1; m_ended = 0; m_err = 0; m_chg = 0;
      end
      if (m_active && m_ended && k == m_done_cyc + 1) m_active = 0;
    end
    exp_ready = !m_active;
    exp_done  = m_active && m_ended && (k == m_done_cyc);
    exp_err   = m_err;
    exp_chg   = m_chg;
    exp_rs5   = 0;
    exp_rs10  = 0;
    exp_paid  = 0;
    foreach (ct[i]) begin
      if (ct[i] <= k) exp_paid = exp_paid + 6'(cv[i]);
      if (ct[i] == k) begin
        if (cv[i] == 10) exp_rs10 = 1;
        else             exp_rs5  = 1;
      end
    end
  endtask

  // Compare DUT outputs with the model in the middle of every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",       ready,       exp_ready);
      check("rs5",         rs5,         exp_rs5);
      check("rs10",        rs10,        exp_rs10);
      check("done",        done,        exp_done);
      check("error",       error,       exp_err);
      check("change_rcvd", change_rcvd, exp_chg);
      check("paid",        paid,        exp_paid);
      check("coin_excl",   rs5 & rs10,  0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic case1();
    start = 1; mode = 0;
    step(); start = 0;
    check("c1_coin1", rs5, 1);  check("c1_paid5", paid, 5);
    step(); check("c1_gap", rs5, 0);
    step(); check("c1_coin2", rs5, 1); check("c1_paid10", paid, 10);
    step();
    step(); check("c1_coin3", rs5, 1); check("c1_paid15", paid, 15);
    step(); item1 = 1; rs5out = 0;
    step(); item1 = 0;
    check("c1_done", done, 1); check("c1_err", error, 0); check("c1_chg", change_rcvd, 0);
    step(); check("c1_ready", ready, 1);
  endtask

  initial begin
    int ndone;
    step(); step();
    chk_en = 1;
    check("rst_ready", ready, 1); check("rst_paid", paid, 0); check("rst_done", done, 0);
    reset = 0;
    step();

    case1();

    start = 1; mode = 1;
    step(); start = 0;
    check("c2_rs10", rs10, 1); check("c2_paid10", paid, 10);
    step(); step();
    check("c2_rs5", rs5, 1); check("c2_paid15", paid, 15);
    step(); item1 = 1; rs5out = 0;
    step(); item1 = 0;
    check("c2_done", done, 1); check("c2_err", error, 0);
    step();

    for (int r = 0; r < 2; r++) begin
      start = 1; mode = 2;
      step(); start = 0;
      check("c3_rs10a", rs10, 1); check("c3_paid10", paid, 10);
      step(); step();
      check("c3_rs10b", rs10, 1); check("c3_paid20", paid, 20);
      step(); item1 = 1; rs5out = (r == 0);
      step(); item1 = 0; rs5out = 0;
      check("c3_done", done, 1);
      check("c3_chg", change_rcvd, (r == 0) ? 1 : 0);
      check("c3_err", error, (r == 0) ? 0 : 1);
      step();
    end

    start = 1; mode = 0;
    step(); start = 0;
    step(); step(); step(); step();
    check("c4_last_coin", rs5, 1);
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i < 9) check("c4_no_done", done, 0);
      else begin check("c4_done", done, 1); check("c4_err", error, 1); end
    end
    step(); check("c4_ready", ready, 1);

    start = 1; mode = 0;
    step(); start = 0;
    step(); item1 = 1;
    step(); item1 = 0;
    check("c5_done", done, 1); check("c5_err", error, 1); check("c5_paid", paid, 5);
    step(); check("c5_nocoin", rs5, 0); check("c5_ready", ready, 1);

    ndone = 0;
    start = 1; mode = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (done) ndone++;
    end
    start = 0;
    check("c5_held_start", ndone, 3);
    step();

    start = 1; mode = 0;
    step(); start = 0;
    step(); reset = 1;
    step(); reset = 0;
    check("c6_paid", paid, 0); check("c6_ready", ready, 1); check("c6_rs5", rs5, 0);
    case1();

    for (int i = 0; i < 600; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      mode   = 2'($urandom_range(0, 3));
      item1  = ($urandom_range(0, 6) == 0);
      rs5out = 1'($urandom_range(0, 1));
      reset  = ($urandom_range(0, 119) == 0);
      step();
    end
    start = 0; item1 = 0; reset = 0;
    for (int i = 0; i < 20; i++) step();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
